// File: rtl/tick_pkg.sv
// tick_pkg: default piano-timebase constants and the playback mode enum.
package tick_pkg;
  localparam int DEF_PRE_W = 14;
  localparam int DEF_PRE_MAX = 10000;
  localparam int DEF_DIV_W = 14;
  localparam int DEF_CNT_W = 8;
  typedef enum logic {MODE_CONT, MODE_ONESHOT} mode_t;
endpackage

// File: rtl/beat_tick_gen_if.sv
// beat_tick_gen_if: control inputs and tick/status outputs of the beat timebase.
interface beat_tick_gen_if #(parameter int DIV_W = 14, parameter int CNT_W = 8);
  logic en;
  logic start;
  logic stop;
  logic oneshot;
  logic [DIV_W-1:0] div_val;
  logic tick;
  logic [CNT_W-1:0] tick_cnt;
  logic busy;
  logic done;
  modport master(output en, start, stop, oneshot, div_val, input tick, tick_cnt, busy, done);
  modport slave(input en, start, stop, oneshot, div_val, output tick, tick_cnt, busy, done);
endinterface

// File: rtl/mod_counter.sv
// mod_counter: modulo counter with programmable terminal count and a wrap strobe.
module mod_counter #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  assign wrap = inc & (cnt == max);
  always_ff @(posedge clk)
    cnt <= (rst | clr | wrap) ? '0 : inc ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/beat_tick_gen.sv
// beat_tick_gen: fixed prescaler feeding a programmable divider; emits beat ticks.
module beat_tick_gen
  import tick_pkg::*;
#(
  parameter int PRE_W = DEF_PRE_W,
  parameter int PRE_MAX = DEF_PRE_MAX,
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  beat_tick_gen_if.slave bus
);
  logic run, clr, pre_wrap, tick, busy, done;
  logic [PRE_W-1:0] pre_cnt;
  logic [DIV_W-1:0] div_cnt, d;
  logic [CNT_W-1:0] tick_cnt;
  mode_t mode;
  assign run = busy & bus.en & ~rst;
  assign clr = bus.start | bus.stop;
  mod_counter #(.W(PRE_W)) u_pre (
    .clk, .rst, .inc(run), .clr, .max(PRE_W'(PRE_MAX)), .cnt(pre_cnt), .wrap(pre_wrap)
  );
  // the divider wraps exactly when its count matches D on a prescaler wrap: that is the tick
  mod_counter #(.W(DIV_W)) u_div (
    .clk, .rst, .inc(pre_wrap), .clr, .max(d), .cnt(div_cnt), .wrap(tick)
  );
  always_ff @(posedge clk) begin
    busy <= rst ? 1'b0 : bus.start ? 1'b1 : (bus.stop | (tick & (mode == MODE_ONESHOT))) ? 1'b0 : busy;
    done <= (rst | bus.start) ? 1'b0 : (tick & (mode == MODE_ONESHOT)) ? 1'b1 : done;
    mode <= rst ? MODE_CONT : bus.start ? (bus.oneshot ? MODE_ONESHOT : MODE_CONT) : mode;
    d <= rst ? '0 : (bus.start | tick) ? bus.div_val : d;
    tick_cnt <= (rst | bus.start) ? '0 : tick ? tick_cnt + 1'b1 : tick_cnt;
  end
  always_ff @(posedge clk)
    if (!rst) assert (pre_cnt <= PRE_W'(PRE_MAX) && div_cnt <= d);
  assign bus.tick = tick;
  assign bus.tick_cnt = tick_cnt;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule

// File: tb/tb_beat_tick_gen.sv
// tb_beat_tick_gen: directed runs with a tick scoreboard on PRE_MAX=3 instances (CNT_W 8 and 2).
module tb_beat_tick_gen;
  typedef struct {int c; int cnt; int busy; int done;} exp_t;
  logic clk = 0, rst = 1;
  int tests = 0, fails = 0, cyc = 0, t0 = 0;
  exp_t q[$];
  beat_tick_gen_if #(.DIV_W(4), .CNT_W(8)) b ();
  beat_tick_gen_if #(.DIV_W(4), .CNT_W(2)) b2 ();
  beat_tick_gen #(.PRE_W(2), .PRE_MAX(3), .DIV_W(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(b));
  beat_tick_gen #(.PRE_W(2), .PRE_MAX(3), .DIV_W(4), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  assign b2.en = b.en;
  assign b2.start = b.start;
  assign b2.stop = b.stop;
  assign b2.oneshot = b.oneshot;
  assign b2.div_val = b.div_val;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, int a, int e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int rel();
    return cyc - t0 + 1;
  endfunction
  task automatic to_rel(int n);
    while (rel() < n) step();
  endtask
  task automatic do_start(logic os, int dv);
    b.oneshot = os;
    b.div_val = 4'(dv);
    b.start = 1;
    step();
    b.start = 0;
    t0 = cyc;
  endtask
  task automatic do_stop();
    b.stop = 1;
    step();
    b.stop = 0;
  endtask
  task automatic push(int r, int cnt, int busy, int done);
    q.push_back('{t0 + r - 1, cnt, busy, done});
  endtask
  always begin
    @(negedge clk);
    if (b.tick) begin
      int c;
      exp_t e;
      c = cyc;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_tick: tick at cycle %0d, none required", c - t0 + 1);
      end else begin
        e = q.pop_front();
        @(posedge clk);
        #1;
        chk("tick_cycle", c - t0 + 1, e.c - t0 + 1);
        chk("tick_cnt", int'(b.tick_cnt), e.cnt);
        chk("tick_cnt_w2", int'(b2.tick_cnt), e.cnt % 4);
        chk("busy_after_tick", int'(b.busy), e.busy);
        chk("done_after_tick", int'(b.done), e.done);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    b.en = 1; b.start = 0; b.stop = 0; b.oneshot = 0; b.div_val = 0;
    repeat (3) step();
    chk("rst_tick", int'(b.tick), 0);
    chk("rst_tick_cnt", int'(b.tick_cnt), 0);
    chk("rst_busy", int'(b.busy), 0);
    chk("rst_done", int'(b.done), 0);
    rst = 0;
    step();
    // continuous, D=2: period 12
    do_start(0, 2);
    push(12, 1, 1, 0); push(24, 2, 1, 0); push(36, 3, 1, 0);
    chk("busy_running", int'(b.busy), 1);
    to_rel(40); do_stop(); to_rel(60);
    chk("cont_missing", q.size(), 0);
    chk("stop_busy", int'(b.busy), 0);
    chk("stop_cnt_held", int'(b.tick_cnt), 3);
    // one-shot, then restart clears done
    do_start(1, 2);
    push(12, 1, 0, 1);
    to_rel(30);
    chk("os_missing", q.size(), 0);
    chk("os_done", int'(b.done), 1);
    chk("os_busy", int'(b.busy), 0);
    do_start(0, 2);
    chk("restart_done", int'(b.done), 0);
    chk("restart_busy", int'(b.busy), 1);
    chk("restart_cnt", int'(b.tick_cnt), 0);
    do_stop();
    // period change latched only at the boundary
    do_start(0, 2);
    push(12, 1, 1, 0); push(16, 2, 1, 0); push(20, 3, 1, 0);
    to_rel(5); b.div_val = 0;
    to_rel(21); do_stop(); to_rel(30);
    chk("reprog_missing", q.size(), 0);
    // pause cycles 6-9
    do_start(0, 2);
    push(16, 1, 1, 0); push(28, 2, 1, 0);
    to_rel(6); b.en = 0;
    to_rel(10); b.en = 1;
    to_rel(29); do_stop(); to_rel(40);
    chk("pause_missing", q.size(), 0);
    // stop coincident with tick
    do_start(0, 2);
    push(12, 1, 0, 0);
    to_rel(12); do_stop(); to_rel(40);
    chk("stoptick_missing", q.size(), 0);
    chk("stoptick_busy", int'(b.busy), 0);
    chk("stoptick_cnt", int'(b.tick_cnt), 1);
    // start and stop together: start wins
    b.stop = 1;
    do_start(0, 2);
    b.stop = 0;
    chk("startstop_busy", int'(b.busy), 1);
    push(12, 1, 1, 0);
    to_rel(13); do_stop(); to_rel(20);
    chk("startstop_missing", q.size(), 0);
    // reset clears a completed one-shot
    do_start(1, 0);
    push(4, 1, 0, 1);
    to_rel(7);
    chk("os0_done", int'(b.done), 1);
    rst = 1; step(); rst = 0;
    chk("rst2_done", int'(b.done), 0);
    chk("rst2_cnt", int'(b.tick_cnt), 0);
    // reset mid-period, start again at cycle 10
    do_start(0, 2);
    to_rel(7);
    rst = 1; step(); rst = 0;
    chk("rst3_busy", int'(b.busy), 0);
    chk("rst3_tick", int'(b.tick), 0);
    to_rel(10);
    b.div_val = 2; b.start = 1;
    push(22, 1, 1, 0);
    step();
    b.start = 0;
    to_rel(23); do_stop(); to_rel(40);
    chk("rst3_missing", q.size(), 0);
    // D=0, five ticks: 8-bit count 1..5, 2-bit count 1,2,3,0,1
    do_start(0, 0);
    for (int i = 1; i <= 5; i++) push(4 * i, i, 1, 0);
    to_rel(21); do_stop(); to_rel(30);
    chk("wrap_missing", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
